// File: rtl/golden_nonce_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_scanner_pkg
// Purpose  : Shared types, constants and digest layout helper for the scanner.
// Revision : 1.0 - initial release
// ============================================================================
package golden_nonce_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_READ        = 3'd1,
        ST_WRITE_FLAG  = 3'd2,
        ST_WRITE_NONCE = 3'd3,
        ST_DONE        = 3'd4
    } scan_state_e;

    localparam int          DIGEST_WORDS         = 8;
    localparam int          WORDS_READ_PER_NONCE = 2;
    localparam logic [31:0] NO_NONCE             = 32'hFFFF_FFFF;
    localparam logic [63:0] NO_HASH              = 64'hFFFF_FFFF_FFFF_FFFF;

    // Word i of digest n; wraps silently at the top of the 16-bit space.
    function automatic logic [15:0] digest_addr(input logic [15:0] base,
                                                input logic [8:0]  n,
                                                input logic [2:0]  i);
        return base + 16'(32'(n) * DIGEST_WORDS) + 16'(i);
    endfunction

endpackage
`default_nettype wire

// File: rtl/golden_nonce_scanner_compare.sv
`default_nettype none
// ============================================================================
// Module   : digest_compare
// Purpose  : Registered first-qualifier and minimum-prefix tracker.
// Revision : 1.0 - initial release
// ============================================================================
module digest_compare
    import golden_nonce_scanner_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        valid,
    input  logic [31:0] target,
    input  logic [31:0] h0,
    input  logic [31:0] h1,
    input  logic [31:0] nonce,
    output logic        found,
    output logic [31:0] golden_nonce,
    output logic [63:0] min_hash,
    output logic [31:0] min_nonce
);

    logic        r_found,        w_found_d;
    logic [31:0] r_golden_nonce, w_golden_nonce_d;
    logic [63:0] r_min_hash,     w_min_hash_d;
    logic [31:0] r_min_nonce,    w_min_nonce_d;

    always_comb begin
        w_found_d        = r_found;
        w_golden_nonce_d = r_golden_nonce;
        w_min_hash_d     = r_min_hash;
        w_min_nonce_d    = r_min_nonce;
        if (clear) begin
            w_found_d        = 1'b0;
            w_golden_nonce_d = NO_NONCE;
            w_min_hash_d     = NO_HASH;
            w_min_nonce_d    = NO_NONCE;
        end else if (valid) begin
            // Only the first qualifier latches; strict compare keeps lowest index on ties.
            if ((h0 < target) && !r_found) begin
                w_found_d        = 1'b1;
                w_golden_nonce_d = nonce;
            end
            if ({h0, h1} < r_min_hash) begin
                w_min_hash_d  = {h0, h1};
                w_min_nonce_d = nonce;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_found        <= 1'b0;
            r_golden_nonce <= NO_NONCE;
            r_min_hash     <= NO_HASH;
            r_min_nonce    <= NO_NONCE;
        end else begin
            r_found        <= w_found_d;
            r_golden_nonce <= w_golden_nonce_d;
            r_min_hash     <= w_min_hash_d;
            r_min_nonce    <= w_min_nonce_d;
        end
    end

    assign found        = r_found;
    assign golden_nonce = r_golden_nonce;
    assign min_hash     = r_min_hash;
    assign min_nonce    = r_min_nonce;

endmodule
`default_nettype wire

// File: rtl/golden_nonce_scanner.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_scanner
// Purpose  : Sweeps stored digests, finds golden nonce and minimum prefix.
// Revision : 1.0 - initial release
// ============================================================================
module golden_nonce_scanner
    import golden_nonce_scanner_pkg::*;
#(
    parameter int          NUM_NONCES = 16,
    parameter logic [31:0] NONCE_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [31:0] golden_nonce,
    output logic [63:0] min_hash,
    output logic [31:0] min_nonce,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int                TOTAL_READS = WORDS_READ_PER_NONCE * NUM_NONCES;
    localparam int                CNT_W       = $clog2(TOTAL_READS + 1);
    localparam logic [CNT_W-1:0]  C_TOTAL     = CNT_W'(TOTAL_READS);

    scan_state_e      r_state,       w_state_d;
    logic [15:0]      r_hash_addr,   w_hash_addr_d;
    logic [15:0]      r_result_addr, w_result_addr_d;
    logic [31:0]      r_target,      w_target_d;
    logic [CNT_W-1:0] r_issue_cnt,   w_issue_cnt_d;
    logic [CNT_W-1:0] r_cap_cnt,     w_cap_cnt_d;
    logic             r_issue_vld,   w_issue_vld_d;
    logic             r_data_vld,    w_data_vld_d;
    logic [31:0]      r_h0,          w_h0_d;
    logic             r_done,        w_done_d;
    logic             r_mem_we,      w_mem_we_d;
    logic [15:0]      r_mem_addr,    w_mem_addr_d;
    logic [31:0]      r_mem_wdata,   w_mem_wdata_d;
    logic             w_launch;
    logic             w_cmp_vld;
    logic [31:0]      w_cmp_nonce;

    assign w_launch    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cmp_nonce = NONCE_BASE + 32'(r_cap_cnt >> 1);

    always_comb begin
        w_state_d       = r_state;
        w_hash_addr_d   = r_hash_addr;
        w_result_addr_d = r_result_addr;
        w_target_d      = r_target;
        w_issue_cnt_d   = r_issue_cnt;
        w_cap_cnt_d     = r_cap_cnt;
        w_issue_vld_d   = 1'b0;
        w_data_vld_d    = 1'b0;
        w_h0_d          = r_h0;
        w_done_d        = r_done;
        w_mem_we_d      = r_mem_we;
        w_mem_addr_d    = r_mem_addr;
        w_mem_wdata_d   = r_mem_wdata;
        w_cmp_vld       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_launch) begin
                    w_state_d       = ST_READ;
                    w_hash_addr_d   = hash_addr;
                    w_result_addr_d = result_addr;
                    w_target_d      = target;
                    w_issue_cnt_d   = CNT_W'(1);
                    w_issue_vld_d   = 1'b1;
                    w_cap_cnt_d     = '0;
                    w_mem_addr_d    = digest_addr(hash_addr, 9'd0, 3'd0);
                    w_done_d        = 1'b0;
                end
            end
            ST_READ: begin
                // Data for the address issued last cycle is on the bus this cycle.
                w_data_vld_d = r_issue_vld;
                if (r_issue_cnt < C_TOTAL) begin
                    w_mem_addr_d  = digest_addr(r_hash_addr, 9'(r_issue_cnt >> 1),
                                                {2'b00, r_issue_cnt[0]});
                    w_issue_cnt_d = r_issue_cnt + CNT_W'(1);
                    w_issue_vld_d = 1'b1;
                end
                if (r_data_vld) begin
                    w_cap_cnt_d = r_cap_cnt + CNT_W'(1);
                    if (!r_cap_cnt[0]) begin
                        w_h0_d = mem_read_data;
                    end else begin
                        w_cmp_vld = 1'b1;
                    end
                end
                if (r_cap_cnt == C_TOTAL) begin
                    w_state_d     = ST_WRITE_FLAG;
                    w_mem_we_d    = 1'b1;
                    w_mem_addr_d  = r_result_addr;
                    w_mem_wdata_d = {31'b0, found};
                end
            end
            ST_WRITE_FLAG: begin
                w_state_d     = ST_WRITE_NONCE;
                w_mem_we_d    = 1'b1;
                w_mem_addr_d  = r_result_addr + 16'd1;
                w_mem_wdata_d = golden_nonce;
            end
            ST_WRITE_NONCE: begin
                w_state_d    = ST_DONE;
                w_mem_we_d   = 1'b0;
                w_mem_addr_d = 16'd0;
                w_done_d     = 1'b1;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hash_addr   <= 16'd0;
            r_result_addr <= 16'd0;
            r_target      <= 32'd0;
            r_issue_cnt   <= '0;
            r_cap_cnt     <= '0;
            r_issue_vld   <= 1'b0;
            r_data_vld    <= 1'b0;
            r_h0          <= 32'd0;
            r_done        <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 16'd0;
            r_mem_wdata   <= 32'd0;
        end else begin
            r_state       <= w_state_d;
            r_hash_addr   <= w_hash_addr_d;
            r_result_addr <= w_result_addr_d;
            r_target      <= w_target_d;
            r_issue_cnt   <= w_issue_cnt_d;
            r_cap_cnt     <= w_cap_cnt_d;
            r_issue_vld   <= w_issue_vld_d;
            r_data_vld    <= w_data_vld_d;
            r_h0          <= w_h0_d;
            r_done        <= w_done_d;
            r_mem_we      <= w_mem_we_d;
            r_mem_addr    <= w_mem_addr_d;
            r_mem_wdata   <= w_mem_wdata_d;
        end
    end

    digest_compare u_compare (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_launch),
        .valid        (w_cmp_vld),
        .target       (r_target),
        .h0           (r_h0),
        .h1           (mem_read_data),
        .nonce        (w_cmp_nonce),
        .found        (found),
        .golden_nonce (golden_nonce),
        .min_hash     (min_hash),
        .min_nonce    (min_nonce)
    );

    assign done           = r_done;
    assign mem_clk        = clk;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;

endmodule
`default_nettype wire
